// File: rtl/bias_acc_sequencer_pkg.sv
// Shared types, sizing and arithmetic helpers for the bias/accumulate sequencer.
package bias_acc_sequencer_pkg;

  localparam int unsigned N_ADDER_TREE = 16;
  localparam int unsigned DW           = 18;
  localparam int unsigned N_GROUPS     = 4;
  localparam int unsigned N_CHUNKS     = 8;
  localparam int unsigned ACC_W        = 24;
  localparam int unsigned GRP_W        = $clog2(N_GROUPS);
  localparam int unsigned CHUNK_W      = $clog2(N_CHUNKS);
  localparam int unsigned VEC_W        = N_ADDER_TREE * DW;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_BIAS,
    ST_OUT,
    ST_DONE
  } state_e;

  // Accumulator must hold N_CHUNKS full-scale words plus one bias without wrapping.
  function automatic bit acc_w_ok(input int unsigned acc_w, input int unsigned dw,
                                  input int unsigned n_chunks);
    return acc_w >= dw + $clog2(n_chunks) + 1;
  endfunction

  // Clamp a signed ACC_W value into the signed DW range.
  function automatic logic [DW-1:0] sat_dw(input logic [ACC_W-1:0] v);
    logic [ACC_W-DW:0] hi_bits;
    hi_bits = v[ACC_W-1:DW-1];
    if ((hi_bits == '0) || (hi_bits == '1)) begin
      return v[DW-1:0];
    end else if (v[ACC_W-1]) begin
      return {1'b1, {(DW-1){1'b0}}};
    end else begin
      return {1'b0, {(DW-1){1'b1}}};
    end
  endfunction

endpackage

// File: rtl/bias_lane_sat.sv
// One lane: chunk accumulator, bias add, DW saturation and optional ReLU.
module bias_lane_sat
  import bias_acc_sequencer_pkg::*;
#(
  parameter bit RELU_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          add_i,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic [DW-1:0] bias_i,
  output logic [DW-1:0] res_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum_c;
  logic [DW-1:0]    sat_c;
  logic [DW-1:0]    res_q, res_d;

  always_comb begin
    acc_d = acc_q;
    res_d = res_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (add_i) begin
      acc_d = acc_q + {{(ACC_W-DW){data_i[DW-1]}}, data_i};
    end
    sum_c = acc_q + {{(ACC_W-DW){bias_i[DW-1]}}, bias_i};
    sat_c = sat_dw(sum_c);
    if (load_i) begin
      res_d = (RELU_EN && sat_c[DW-1]) ? '0 : sat_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      res_q <= '0;
    end else begin
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

  assign res_o = res_q;

endmodule

// File: rtl/bias_acc_sequencer.sv
// Walks each output-channel group through chunk accumulation, bias add and hand-off.
module bias_acc_sequencer
  import bias_acc_sequencer_pkg::*;
#(
  parameter bit RELU_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] in_data,
  output logic [GRP_W-1:0] bias_sel,
  input  logic [VEC_W-1:0] bias_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VEC_W-1:0] out_data,
  output logic [GRP_W-1:0] out_group
);

  if (!acc_w_ok(ACC_W, DW, N_CHUNKS)) begin : g_acc_w_check
    $error("ACC_W too narrow for DW and N_CHUNKS");
  end

  state_e               state_q, state_d;
  logic [GRP_W-1:0]     group_q, group_d;
  logic [CHUNK_W-1:0]   chunk_q, chunk_d;
  logic [GRP_W-1:0]     out_group_q, out_group_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 acc_clr_c, acc_add_c, res_load_c;

  always_comb begin
    state_d     = state_q;
    group_d     = group_q;
    chunk_d     = chunk_q;
    out_group_d = out_group_q;
    acc_clr_c   = 1'b0;
    acc_add_c   = 1'b0;
    res_load_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_clr_c = 1'b1;
          group_d   = '0;
          chunk_d   = '0;
          state_d   = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (in_valid) begin
          acc_add_c = 1'b1;
          if (chunk_q == CHUNK_W'(N_CHUNKS - 1)) begin
            chunk_d = '0;
            state_d = ST_BIAS;
          end else begin
            chunk_d = chunk_q + CHUNK_W'(1);
          end
        end
      end
      ST_BIAS: begin
        res_load_c  = 1'b1;
        out_group_d = group_q;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          if (group_q == GRP_W'(N_GROUPS - 1)) begin
            state_d = ST_DONE;
          end else begin
            group_d   = group_q + GRP_W'(1);
            acc_clr_c = 1'b1;
            state_d   = ST_ACCUM;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Status outputs are registered copies of the next state.
    busy_d      = (state_d != ST_IDLE);
    in_ready_d  = (state_d == ST_ACCUM);
    out_valid_d = (state_d == ST_OUT);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      group_q     <= '0;
      chunk_q     <= '0;
      out_group_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      group_q     <= group_d;
      chunk_q     <= chunk_d;
      out_group_q <= out_group_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  for (genvar i = 0; i < N_ADDER_TREE; i++) begin : g_lane
    bias_lane_sat #(
      .RELU_EN (RELU_EN)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (acc_clr_c),
      .add_i  (acc_add_c),
      .load_i (res_load_c),
      .data_i (in_data[DW*i +: DW]),
      .bias_i (bias_q[DW*i +: DW]),
      .res_o  (out_data[DW*i +: DW])
    );
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bias_sel  = group_q;
  assign out_group = out_group_q;

endmodule

// File: tb/tb_bias_acc_sequencer.sv
// Directed scoreboard bench for bias_acc_sequencer, with ReLU on and off instances in lockstep.
module tb_bias_acc_sequencer;
  import bias_acc_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [VEC_W-1:0] in_data = '0;
  logic [VEC_W-1:0] bias_q;

  logic busy, done, in_ready, out_valid;
  logic [GRP_W-1:0] bias_sel, out_group;
  logic [VEC_W-1:0] out_data;
  logic busy_nr, done_nr, in_ready_nr, out_valid_nr;
  logic [GRP_W-1:0] bias_sel_nr, out_group_nr;
  logic [VEC_W-1:0] out_data_nr;

  logic [VEC_W-1:0] bias_bank [N_GROUPS];
  assign bias_q = bias_bank[bias_sel];

  always #5 clk = ~clk;

  bias_acc_sequencer #(.RELU_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .bias_sel(bias_sel), .bias_q(bias_q), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_group(out_group)
  );

  bias_acc_sequencer #(.RELU_EN(1'b0)) u_dut_nr (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_nr), .done(done_nr),
    .in_valid(in_valid), .in_ready(in_ready_nr), .in_data(in_data),
    .bias_sel(bias_sel_nr), .bias_q(bias_q), .out_valid(out_valid_nr),
    .out_ready(out_ready), .out_data(out_data_nr), .out_group(out_group_nr)
  );

  typedef struct {
    logic [VEC_W-1:0] relu;
    logic [VEC_W-1:0] raw;
    logic [GRP_W-1:0] grp;
  } exp_t;

  exp_t sb[$];
  int   macc [N_ADDER_TREE];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat_ref(input int v);
    if (v > (1 << (DW-1)) - 1) return (1 << (DW-1)) - 1;
    if (v < -(1 << (DW-1))) return -(1 << (DW-1));
    return v;
  endfunction

  function automatic logic [VEC_W-1:0] gen_vec(input int kind, input int c);
    logic [VEC_W-1:0] v;
    int x;
    v = '0;
    for (int i = 0; i < N_ADDER_TREE; i++) begin
      case (kind)
        0: x = 100;
        1: x = 100 * i - 700 + 13 * c;
        2: x = 131071;
        3: x = -131072;
        default: x = int'($urandom_range(40000)) - 20000;
      endcase
      v[i*DW +: DW] = DW'(x);
    end
    return v;
  endfunction

  task automatic send_beat(input logic [VEC_W-1:0] vec);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = vec;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("beat_ready", VEC_W'(in_ready), VEC_W'(1));
    tick();
    for (int i = 0; i < N_ADDER_TREE; i++) macc[i] += int'($signed(vec[i*DW +: DW]));
  endtask

  task automatic push_expected(input int g);
    exp_t e;
    int r;
    e.relu = '0;
    e.raw  = '0;
    for (int i = 0; i < N_ADDER_TREE; i++) begin
      r = sat_ref(macc[i] + int'($signed(bias_bank[g][i*DW +: DW])));
      e.raw[i*DW +: DW]  = DW'(r);
      e.relu[i*DW +: DW] = DW'((r < 0) ? 0 : r);
    end
    e.grp = GRP_W'(g);
    sb.push_back(e);
  endtask

  task automatic start_pass();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", VEC_W'(busy), VEC_W'(1));
    chk("start_in_ready", VEC_W'(in_ready), VEC_W'(1));
    chk("start_bias_sel", VEC_W'(bias_sel), '0);
  endtask

  task automatic send_group(input int g, input int kind, input bit gaps);
    for (int i = 0; i < N_ADDER_TREE; i++) macc[i] = 0;
    chk("accum_bias_sel", VEC_W'(bias_sel), VEC_W'(g));
    chk("accum_bias_sel_nr", VEC_W'(bias_sel_nr), VEC_W'(g));
    for (int c = 0; c < N_CHUNKS; c++) begin
      if (gaps) begin
        in_valid = 1'b0;
        in_data  = gen_vec(4, 0);
        repeat ($urandom_range(2)) tick();
      end
      send_beat(gen_vec(kind, c));
    end
    in_valid = 1'b0;
    chk("bias_in_ready", VEC_W'(in_ready), '0);
    chk("bias_out_valid", VEC_W'(out_valid), '0);
    chk("bias_bias_sel", VEC_W'(bias_sel), VEC_W'(g));
    push_expected(g);
    tick();
    chk("out_latency", VEC_W'(out_valid), VEC_W'(1));
  endtask

  task automatic expect_out(input bit last, input bit stall);
    exp_t e;
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("out_valid", VEC_W'(out_valid), VEC_W'(1));
    chk("out_valid_nr", VEC_W'(out_valid_nr), VEC_W'(1));
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    chk("out_data_relu", out_data, e.relu);
    chk("out_data_raw", out_data_nr, e.raw);
    chk("out_group", VEC_W'(out_group), VEC_W'(e.grp));
    chk("out_group_nr", VEC_W'(out_group_nr), VEC_W'(e.grp));
    chk("out_bias_sel", VEC_W'(bias_sel), VEC_W'(e.grp));
    if (stall) begin
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
        in_data = gen_vec(4, k);
        start   = (k == 1);
        tick();
        chk("stall_data", out_data, e.relu);
        chk("stall_data_nr", out_data_nr, e.raw);
        chk("stall_in_ready", VEC_W'(in_ready), '0);
        chk("stall_out_valid", VEC_W'(out_valid), VEC_W'(1));
      end
      in_valid = 1'b0;
      start    = 1'b0;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_drop", VEC_W'(out_valid), '0);
    if (last) begin
      chk("done_pulse", VEC_W'(done), VEC_W'(1));
      chk("done_pulse_nr", VEC_W'(done_nr), VEC_W'(1));
      tick();
      chk("done_low", VEC_W'(done), '0);
      chk("idle_busy", VEC_W'(busy), '0);
    end
  endtask

  initial begin
    int base;
    for (int g = 0; g < N_GROUPS; g++) bias_bank[g] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", VEC_W'(busy), '0);
    chk("rst_done", VEC_W'(done), '0);
    chk("rst_in_ready", VEC_W'(in_ready), '0);
    chk("rst_out_valid", VEC_W'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_group", VEC_W'(out_group), '0);
    chk("rst_bias_sel", VEC_W'(bias_sel), '0);
    chk("rst_busy_nr", VEC_W'(busy_nr), '0);
    chk("rst_in_ready_nr", VEC_W'(in_ready_nr), '0);
    chk("rst_out_data_nr", out_data_nr, '0);
    rst_n = 1'b1;
    tick();

    // Abort a pass three chunks in with an asynchronous reset.
    for (int g = 0; g < N_GROUPS; g++)
      for (int i = 0; i < N_ADDER_TREE; i++) bias_bank[g][i*DW +: DW] = DW'(1000);
    start_pass();
    for (int c = 0; c < 3; c++) send_beat(gen_vec(0, c));
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", VEC_W'(busy), '0);
    chk("midrst_in_ready", VEC_W'(in_ready), '0);
    chk("midrst_out_valid", VEC_W'(out_valid), '0);
    chk("midrst_busy_nr", VEC_W'(busy_nr), '0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // Nominal pass, bias +1000 everywhere.
    base = done_cnt;
    start_pass();
    send_group(0, 0, 1'b0);
    expect_out(1'b0, 1'b0);
    send_group(1, 1, 1'b0);
    expect_out(1'b0, 1'b0);
    send_group(2, 0, 1'b1);
    expect_out(1'b0, 1'b1);
    send_group(3, 1, 1'b0);
    expect_out(1'b1, 1'b0);
    repeat (2) tick();
    chk("done_count_pass1", VEC_W'(done_cnt - base), VEC_W'(1));

    // Saturation, ReLU, random stalls and stray control inputs.
    for (int i = 0; i < N_ADDER_TREE; i++) begin
      bias_bank[0][i*DW +: DW] = DW'(0);
      bias_bank[1][i*DW +: DW] = DW'(-1000);
      bias_bank[2][i*DW +: DW] = DW'(int'($urandom_range(2000)) - 1000);
      bias_bank[3][i*DW +: DW] = DW'(500 * i - 4000);
    end
    base = done_cnt;
    start_pass();
    send_group(0, 2, 1'b0);
    expect_out(1'b0, 1'b0);
    send_group(1, 3, 1'b0);
    expect_out(1'b0, 1'b1);
    send_group(2, 4, 1'b1);
    expect_out(1'b0, 1'b0);
    send_group(3, 4, 1'b1);
    expect_out(1'b1, 1'b1);
    repeat (2) tick();
    chk("done_count_pass2", VEC_W'(done_cnt - base), VEC_W'(1));
    chk("final_idle_busy", VEC_W'(busy), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
